aftab_imm_sel_controller: RTL and testbench

Sequencing controller for the AFTAB immediate sign-extension unit. It accepts a 32-bit instruction word over a valid/ready handshake and holds it in an internal instruction register. It decodes the RV32I opcode into an immediate format, drives the one-hot-group select lines and IR field slices that the sign-extension unit consumes, and presents the result to the datapath through a second valid/ready handshake. It sits between instruction fetch/decode and the immSelSignExt datapath stage, and also flags unsupported opcodes.

---
 rtl/aftab_imm_sel_controller.sv | 166 ++++++++++++++++
 tb/tb_aftab_imm_sel_controller.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/aftab_imm_sel_controller.sv
`default_nettype none
// ============================================================================
// Module  : aftab_imm_sel_controller
// Brief   : Captures an RV32I instruction, decodes its immediate format and
//           drives registered select lines / IR slices to immSelSignExt.
// Rev     : 1.0  initial release
// ============================================================================
module aftab_imm_sel_controller #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             instr_valid,
  input  logic [XLEN-1:0]  instr,
  output logic             instr_ready,
  input  logic             imm_ready,
  output logic             imm_valid,
  output logic [2:0]       fmt,
  output logic             illegal,
  output logic             IR7,
  output logic             IR20,
  output logic             IR31,
  output logic [3:0]       IR11_8,
  output logic [7:0]       IR19_12,
  output logic [3:0]       IR24_21,
  output logic [5:0]       IR30_25,
  output logic             selI,
  output logic             selS,
  output logic             selBUJ,
  output logic             selIJ,
  output logic             selSB,
  output logic             selU,
  output logic             selISBJ,
  output logic             selIS,
  output logic             selB,
  output logic             selJ,
  output logic             selISB,
  output logic             selUJ,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_VALID  = 2'd2
  } state_t;

  localparam logic [2:0]       C_FMT_NONE = 3'd0;
  localparam logic [2:0]       C_FMT_I    = 3'd1;
  localparam logic [2:0]       C_FMT_S    = 3'd2;
  localparam logic [2:0]       C_FMT_B    = 3'd3;
  localparam logic [2:0]       C_FMT_U    = 3'd4;
  localparam logic [2:0]       C_FMT_J    = 3'd5;
  localparam logic [2:0]       C_FMT_ILL  = 3'd7;
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  state_t            r_state;
  logic [XLEN-1:0]   r_ir;
  logic [2:0]        r_fmt;
  logic [11:0]       r_sel;
  logic              r_illegal;
  logic              r_imm_valid;
  logic [CNT_W-1:0]  r_cnt;

  logic [2:0]        w_fmt;
  logic [11:0]       w_sel;

  always_comb begin
    w_fmt = C_FMT_ILL;
    case (r_ir[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: w_fmt = C_FMT_I;
      7'b0100011:                                     w_fmt = C_FMT_S;
      7'b1100011:                                     w_fmt = C_FMT_B;
      7'b0110111, 7'b0010111:                         w_fmt = C_FMT_U;
      7'b1101111:                                     w_fmt = C_FMT_J;
      7'b0110011:                                     w_fmt = C_FMT_NONE;
      default:                                        w_fmt = C_FMT_ILL;
    endcase
  end

  // Bit order: I S BUJ IJ SB U ISBJ IS B J ISB UJ
  always_comb begin
    w_sel = 12'b0;
    case (w_fmt)
      C_FMT_I: w_sel = 12'b1001_0011_0010;
      C_FMT_S: w_sel = 12'b0100_1011_0010;
      C_FMT_B: w_sel = 12'b0010_1010_1010;
      C_FMT_U: w_sel = 12'b0010_0100_0001;
      C_FMT_J: w_sel = 12'b0011_0010_0101;
      default: w_sel = 12'b0;
    endcase
  end

  // Only combinational input-to-output path: imm_ready -> instr_ready in VALID.
  assign instr_ready = (r_state == S_IDLE) || ((r_state == S_VALID) && imm_ready);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_ir        <= '0;
      r_fmt       <= C_FMT_NONE;
      r_sel       <= '0;
      r_illegal   <= 1'b0;
      r_imm_valid <= 1'b0;
      r_cnt       <= '0;
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_ir        <= '0;
      r_fmt       <= C_FMT_NONE;
      r_sel       <= '0;
      r_illegal   <= 1'b0;
      r_imm_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (instr_valid) begin
            r_ir    <= instr;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_fmt       <= w_fmt;
          r_sel       <= w_sel;
          r_illegal   <= (w_fmt == C_FMT_ILL);
          r_imm_valid <= 1'b1;
          r_state     <= S_VALID;
          if ((w_fmt == C_FMT_ILL) && (r_cnt != '1)) begin
            r_cnt <= r_cnt + C_CNT_ONE;
          end
        end
        S_VALID: begin
          if (imm_ready) begin
            r_imm_valid <= 1'b0;
            if (instr_valid) begin
              r_ir    <= instr;
              r_state <= S_DECODE;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imm_valid   = r_imm_valid;
  assign fmt         = r_fmt;
  assign illegal     = r_illegal;
  assign illegal_cnt = r_cnt;

  assign IR7     = r_ir[7];
  assign IR11_8  = r_ir[11:8];
  assign IR19_12 = r_ir[19:12];
  assign IR20    = r_ir[20];
  assign IR24_21 = r_ir[24:21];
  assign IR30_25 = r_ir[30:25];
  assign IR31    = r_ir[31];

  assign {selI, selS, selBUJ, selIJ, selSB, selU,
          selISBJ, selIS, selB, selJ, selISB, selUJ} = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_aftab_imm_sel_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_aftab_imm_sel_controller
// Brief   : Randomized self-checking bench for aftab_imm_sel_controller.
// Rev     : 1.0  initial release
// ============================================================================
module tb_aftab_imm_sel_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        imm_ready = 1'b0;
  logic        instr_ready, imm_valid, illegal;
  logic [2:0]  fmt;
  logic        IR7, IR20, IR31;
  logic [3:0]  IR11_8, IR24_21;
  logic [7:0]  IR19_12;
  logic [5:0]  IR30_25;
  logic        selI, selS, selBUJ, selIJ, selSB, selU;
  logic        selISBJ, selIS, selB, selJ, selISB, selUJ;
  logic [7:0]  illegal_cnt;
  logic [11:0] w_sels;

  int          n_chk = 0;
  int          n_bad = 0;
  logic [7:0]  exp_cnt = 8'h0;
  logic [31:0] last = 32'h0;
  bit          held = 1'b0;

  always #5 clk = ~clk;

  aftab_imm_sel_controller #(.XLEN(32), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .imm_ready(imm_ready), .imm_valid(imm_valid), .fmt(fmt), .illegal(illegal),
    .IR7(IR7), .IR20(IR20), .IR31(IR31), .IR11_8(IR11_8), .IR19_12(IR19_12),
    .IR24_21(IR24_21), .IR30_25(IR30_25),
    .selI(selI), .selS(selS), .selBUJ(selBUJ), .selIJ(selIJ), .selSB(selSB),
    .selU(selU), .selISBJ(selISBJ), .selIS(selIS), .selB(selB), .selJ(selJ),
    .selISB(selISB), .selUJ(selUJ), .illegal_cnt(illegal_cnt)
  );

  assign w_sels = {selI, selS, selBUJ, selIJ, selSB, selU,
                   selISBJ, selIS, selB, selJ, selISB, selUJ};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [2:0] ref_fmt(input logic [6:0] op);
    if (op inside {7'h03, 7'h13, 7'h67, 7'h73}) return 3'd1;
    if (op == 7'h23) return 3'd2;
    if (op == 7'h63) return 3'd3;
    if (op inside {7'h37, 7'h17}) return 3'd4;
    if (op == 7'h6F) return 3'd5;
    if (op == 7'h33) return 3'd0;
    return 3'd7;
  endfunction

  // Each select lists the formats it serves, as a mask indexed by fmt code.
  function automatic logic [11:0] ref_sels(input logic [2:0] f);
    logic [7:0]  m [12];
    logic [11:0] r;
    m = '{8'h02, 8'h04, 8'h38, 8'h22, 8'h0C, 8'h10,
          8'h2E, 8'h06, 8'h08, 8'h20, 8'h0E, 8'h30};
    r = '0;
    for (int k = 0; k < 12; k++) r[11-k] = m[k][f];
    return r;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [6:0]  ops [10];
    logic [31:0] w;
    ops = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
    w = $urandom;
    if ($urandom_range(0, 3) == 0) w[6:0] = 7'($urandom);
    else                           w[6:0] = ops[$urandom_range(0, 9)];
    return w;
  endfunction

  task automatic chk_ir(input logic [31:0] e);
    chk("IR7",     32'(IR7),     32'(e[7]));
    chk("IR11_8",  32'(IR11_8),  32'(e[11:8]));
    chk("IR19_12", 32'(IR19_12), 32'(e[19:12]));
    chk("IR20",    32'(IR20),    32'(e[20]));
    chk("IR24_21", 32'(IR24_21), 32'(e[24:21]));
    chk("IR30_25", 32'(IR30_25), 32'(e[30:25]));
    chk("IR31",    32'(IR31),    32'(e[31]));
  endtask

  task automatic chk_dec(input logic [31:0] e);
    logic [2:0] f;
    f = ref_fmt(e[6:0]);
    chk("fmt",     32'(fmt),         32'(f));
    chk("sels",    32'(w_sels),      32'(ref_sels(f)));
    chk("illegal", 32'(illegal),     32'(f == 3'd7));
    chk("cnt",     32'(illegal_cnt), 32'(exp_cnt));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rdy"},   32'(instr_ready), 32'd1);
    chk({tag, "_vld"},   32'(imm_valid),   32'd0);
    chk({tag, "_fmt"},   32'(fmt),         32'd0);
    chk({tag, "_ill"},   32'(illegal),     32'd0);
    chk({tag, "_sels"},  32'(w_sels),      32'd0);
    chk({tag, "_cnt"},   32'(illegal_cnt), 32'd0);
    chk_ir(32'h0);
  endtask

  // Deliver one instruction; if one is already held, stall then hand off back-to-back.
  task automatic send(input logic [31:0] ins, input int stall);
    if (held) begin
      imm_ready   = 1'b0;
      instr_valid = 1'b1;
      instr       = ins;
      repeat (stall) begin
        @(posedge clk); #1;
        chk("stall_vld", 32'(imm_valid),   32'd1);
        chk("stall_rdy", 32'(instr_ready), 32'd0);
        chk_ir(last);
        chk_dec(last);
      end
      imm_ready = 1'b1;
      #1 chk("b2b_rdy", 32'(instr_ready), 32'd1);
    end else begin
      imm_ready   = 1'b0;
      instr_valid = 1'b1;
      instr       = ins;
      #1 chk("idle_rdy", 32'(instr_ready), 32'd1);
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    imm_ready   = 1'b0;
    #1;
    chk("dec_vld", 32'(imm_valid),   32'd0);
    chk("dec_rdy", 32'(instr_ready), 32'd0);
    chk_ir(ins);
    if (ref_fmt(ins[6:0]) == 3'd7 && exp_cnt != 8'hFF) exp_cnt++;
    @(posedge clk); #1;
    chk("valid", 32'(imm_valid), 32'd1);
    chk_ir(ins);
    chk_dec(ins);
    last = ins;
    held = 1'b1;
  endtask

  task automatic release_to_idle();
    imm_ready   = 1'b1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    chk("rel_vld", 32'(imm_valid),   32'd0);
    chk("rel_rdy", 32'(instr_ready), 32'd1);
    imm_ready = 1'b0;
    held      = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] sweep [4];
    logic [7:0]  cnt_before;
    sweep = '{32'h00112623, 32'h00000463, 32'h123450B7, 32'h008000EF};

    rst = 1'b0; instr_valid = 1'b1; instr = 32'hFFF00093;
    repeat (2) @(posedge clk);
    #1 chk_reset("rst");
    rst = 1'b1; instr_valid = 1'b0;

    send(32'hFFF00093, 0);
    chk("addi_IR31", 32'(IR31), 32'd1);
    for (int i = 0; i < 4; i++) send(sweep[i], 1);

    send(32'h00A00513, 5);
    release_to_idle();

    // Flush while DECODE holds an illegal opcode: counter must not move.
    cnt_before  = exp_cnt;
    instr_valid = 1'b1; instr = 32'h0000007F;
    @(posedge clk); #1;
    flush = 1'b1; instr = 32'h00100093;
    @(posedge clk); #1;
    flush = 1'b0; instr_valid = 1'b0;
    chk("fl_vld",  32'(imm_valid),   32'd0);
    chk("fl_rdy",  32'(instr_ready), 32'd1);
    chk("fl_sels", 32'(w_sels),      32'd0);
    chk_ir(32'h0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("fl_quiet", 32'(imm_valid), 32'd0);
    end
    chk("fl_cnt", 32'(illegal_cnt), 32'(cnt_before));

    for (int i = 0; i < 60; i++) begin
      send(rnd_instr(), $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) release_to_idle();
    end

    for (int i = 0; i < 260; i++) send({25'($urandom), 7'h7F}, 0);
    chk("sat_cnt", 32'(illegal_cnt), 32'hFF);

    rst = 1'b0; instr_valid = 1'b1; imm_ready = 1'b0;
    @(posedge clk); #1;
    chk_reset("midrst");
    rst = 1'b1; instr_valid = 1'b0;
    exp_cnt = 8'h0; held = 1'b0;
    send(32'h0000007F, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
